// File: rtl/lwdf_adaptor_sequencer_if.sv
// Sample / adaptor / output handshake bundle for the LWDF adaptor sequencer.
// The stall_cnt status field exists only when LWDF_STATUS_EN is defined.
interface lwdf_adaptor_sequencer_if #(
    parameter int N_ADAPTORS = 3
);
    localparam int IDX_W = (N_ADAPTORS > 1) ? $clog2(N_ADAPTORS) : 1;

    logic             in_valid;
    logic             in_ready;
    logic             sample_we;
    logic             adp_start;
    logic [IDX_W-1:0] adp_idx;
    logic             adp_done;
    logic             state_we;
    logic             out_valid;
    logic             out_ready;
    logic             busy;
    logic             err;
`ifdef LWDF_STATUS_EN
    logic [7:0]       stall_cnt;
`endif

    modport master (
        input  in_valid, adp_done, out_ready,
        output in_ready, sample_we, adp_start, adp_idx,
        output state_we, out_valid, busy, err
`ifdef LWDF_STATUS_EN
        , output stall_cnt
`endif
    );

    modport slave (
        output in_valid, adp_done, out_ready,
        input  in_ready, sample_we, adp_start, adp_idx,
        input  state_we, out_valid, busy, err
`ifdef LWDF_STATUS_EN
        , input stall_cnt
`endif
    );
endinterface

// File: rtl/lwdf_adaptor_sequencer.sv
// Time-multiplexes one two-port adaptor datapath over all LWDF adaptors.
// Optional macro LWDF_STATUS_EN adds the saturating stall_cnt status counter.
module lwdf_adaptor_sequencer #(
    parameter int N_ADAPTORS = 3,
    parameter int TIMEOUT    = 15
) (
    input  logic clk,
    input  logic rst,
    lwdf_adaptor_sequencer_if.master bus
);
    localparam int IDX_W = (N_ADAPTORS > 1) ? $clog2(N_ADAPTORS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ADAPTORS - 1);
    localparam logic [7:0] WD_INIT = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        OUT
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [7:0]       wd_q, wd_d;
    logic             err_q, err_d;
    logic             sample_we_q, sample_we_d;
    logic             ready;

    assign ready         = (state_q == IDLE);
    assign bus.in_ready  = ready;
    assign bus.busy      = (state_q != IDLE);
    assign bus.adp_start = (state_q == ISSUE);
    assign bus.out_valid = (state_q == OUT);
    assign bus.sample_we = sample_we_q;
    assign bus.adp_idx   = idx_q;
    assign bus.err       = err_q;
    // Commit coincides with adp_done so the write index is still the finished adaptor
    assign bus.state_we  = (state_q == WAIT) && bus.adp_done;

    // State, index, watchdog and sticky error registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            wd_q        <= '0;
            err_q       <= 1'b0;
            sample_we_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            wd_q        <= wd_d;
            err_q       <= err_d;
            sample_we_q <= sample_we_d;
        end
    end

    // Next-state: sample latch, adaptor issue/wait loop, timeout abort, output hold
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        wd_d        = wd_q;
        err_d       = err_q;
        sample_we_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    sample_we_d = 1'b1;
                    idx_d       = '0;
                    wd_d        = WD_INIT;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                wd_d    = wd_q - 8'd1;
                state_d = WAIT;
            end
            WAIT: begin
                wd_d = wd_q - 8'd1;
                if (bus.adp_done) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = OUT;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        wd_d    = WD_INIT;
                        state_d = ISSUE;
                    end
                end else if (wd_q <= 8'd1) begin
                    err_d   = 1'b1;
                    idx_d   = '0;
                    state_d = IDLE;
                end
            end
            OUT: begin
                if (bus.out_ready) begin
                    idx_d   = '0;
                    state_d = IDLE;
                end
            end
        endcase
    end

`ifdef LWDF_STATUS_EN
    logic [7:0] stall_q;

    // Count cycles where upstream waits on the sequencer, saturating at 255
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
        end else if (bus.in_valid && !ready && stall_q != 8'hFF) begin
            stall_q <= stall_q + 8'd1;
        end
    end

    assign bus.stall_cnt = stall_q;
`endif
endmodule

// File: tb/tb_lwdf_adaptor_sequencer.sv
// Scoreboard bench for lwdf_adaptor_sequencer (N=3, TIMEOUT=15, adaptor L=2).
// Checks ordering, latency, backpressure, timeout, reset abort and spurious done.
module tb_lwdf_adaptor_sequencer;
    localparam int N  = 3;
    localparam int TO = 15;
    localparam int L  = 2;
    localparam int LAT = 1 + N * (1 + L);

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    int   exp_start_q[$];
    int   exp_we_q[$];
    int   exp_out_q[$];
    int   we_cnt = 0;
    int   last_sw = -1;
    int   last_start = -1;
    int   drop_idx = -1;
    bit   force_done = 1'b0;
    bit   prev_out = 1'b0;

    lwdf_adaptor_sequencer_if #(.N_ADAPTORS(N)) bus ();

    lwdf_adaptor_sequencer #(
        .N_ADAPTORS(N),
        .TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Adaptor model: done pulse L cycles after start, optionally dropped
    initial begin : adaptor_model
        int cnt;
        cnt = 0;
        bus.adp_done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.adp_done = force_done;
            if (rst) begin
                cnt = 0;
            end else begin
                if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) bus.adp_done = 1'b1;
                end
                if (bus.adp_start && int'(bus.adp_idx) != drop_idx) cnt = L;
            end
        end
    end

    // Monitor: pops scoreboard entries as the DUT produces events
    initial begin : monitor
        int e;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_out = 1'b0;
            end else begin
                if (bus.sample_we) last_sw = cyc;
                if (bus.adp_start) begin
                    last_start = cyc;
                    tests++;
                    if (exp_start_q.size() == 0) begin
                        fails++;
                        $display("FAIL start_unexp: adp_start idx=%0d at cyc %0d, none expected",
                                 bus.adp_idx, cyc);
                    end else begin
                        e = exp_start_q.pop_front();
                        if (int'(bus.adp_idx) !== e) begin
                            fails++;
                            $display("FAIL start_idx: got %0d want %0d", bus.adp_idx, e);
                        end
                    end
                end
                if (bus.state_we) begin
                    we_cnt++;
                    tests++;
                    if (exp_we_q.size() == 0) begin
                        fails++;
                        $display("FAIL we_unexp: state_we idx=%0d at cyc %0d, none expected",
                                 bus.adp_idx, cyc);
                    end else begin
                        e = exp_we_q.pop_front();
                        if (int'(bus.adp_idx) !== e) begin
                            fails++;
                            $display("FAIL we_idx: got %0d want %0d", bus.adp_idx, e);
                        end
                    end
                end
                if (bus.out_valid && !prev_out) begin
                    tests++;
                    if (exp_out_q.size() == 0) begin
                        fails++;
                        $display("FAIL out_unexp: out_valid at cyc %0d, none expected", cyc);
                    end else begin
                        e = exp_out_q.pop_front();
                        if (cyc !== e) begin
                            fails++;
                            $display("FAIL out_time: got cyc %0d want %0d", cyc, e);
                        end
                    end
                end
                prev_out = bus.out_valid;
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        force_done = 1'b0;
        drop_idx = -1;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        exp_start_q.delete();
        exp_we_q.delete();
        exp_out_q.delete();
    endtask

    task automatic accept(input int n_start, input int n_we, input bit want_out,
                          output int acc);
        acc = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) begin
                acc = cyc;
                break;
            end
        end
        tests++;
        if (acc < 0) begin
            fails++;
            $display("FAIL accept: no accept within 100 cycles");
        end else begin
            for (int k = 0; k < n_start; k++) exp_start_q.push_back(k);
            for (int k = 0; k < n_we; k++) exp_we_q.push_back(k);
            if (want_out) exp_out_q.push_back(acc + LAT);
        end
    endtask

    task automatic send(input int n_start, input int n_we, input bit want_out,
                        output int acc);
        @(posedge clk);
        #1 bus.in_valid = 1'b1;
        accept(n_start, n_we, want_out, acc);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(output int c);
        c = -1;
        for (int i = 0; i < 100; i++) begin
            if (bus.out_valid) begin
                c = cyc;
                break;
            end
            @(negedge clk);
        end
        tests++;
        if (c < 0) begin
            fails++;
            $display("FAIL out_wait: out_valid not seen within 100 cycles");
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        tests++;
        if ({bus.in_ready, bus.busy, bus.err, bus.out_valid} !== 4'b1000) begin
            fails++;
            $display("FAIL reset_status: rdy/busy/err/ov=%b want 1000",
                     {bus.in_ready, bus.busy, bus.err, bus.out_valid});
        end
        tests++;
        if ({bus.sample_we, bus.adp_start, bus.state_we, bus.adp_idx} !== 5'b0) begin
            fails++;
            $display("FAIL reset_pulses: sw/st/we/idx=%b want 0",
                     {bus.sample_we, bus.adp_start, bus.state_we, bus.adp_idx});
        end
`ifdef LWDF_STATUS_EN
        tests++;
        if (bus.stall_cnt !== 8'd0) begin
            fails++;
            $display("FAIL reset_stall: got %0d want 0", bus.stall_cnt);
        end
`endif
    endtask

    task automatic test_single();
        int acc, c, w0;
        w0 = we_cnt;
        bus.out_ready = 1'b1;
        send(N, N, 1'b1, acc);
        wait_out(c);
        tests++;
        if (last_sw !== acc + 1) begin
            fails++;
            $display("FAIL sample_we_time: got %0d want %0d", last_sw, acc + 1);
        end
        tests++;
        if (c !== acc + LAT) begin
            fails++;
            $display("FAIL latency: got %0d want %0d", c - acc, LAT);
        end
        @(negedge clk);
        tests++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL out_pulse: ov=%b rdy=%b want 0 1", bus.out_valid, bus.in_ready);
        end
        tests++;
        if (we_cnt - w0 !== N) begin
            fails++;
            $display("FAIL we_count: got %0d want %0d", we_cnt - w0, N);
        end
    endtask

    task automatic test_backpressure();
        int acc, c;
        bus.out_ready = 1'b0;
        send(N, N, 1'b1, acc);
        wait_out(c);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tests++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
                fails++;
                $display("FAIL hold_%0d: ov=%b rdy=%b want 1 0", i, bus.out_valid,
                         bus.in_ready);
            end
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        @(negedge clk);
        tests++;
        if (bus.out_valid !== 1'b1) begin
            fails++;
            $display("FAIL release_same: ov=%b want 1", bus.out_valid);
        end
        @(negedge clk);
        tests++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            fails++;
            $display("FAIL release_idle: rdy=%b ov=%b want 1 0", bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_timeout();
        int acc, ec, c, w0;
        drop_idx = 1;
        w0 = we_cnt;
        send(2, 1, 1'b0, acc);
        ec = -1;
        for (int i = 0; i < 100; i++) begin
            if (bus.err) begin
                ec = cyc;
                break;
            end
            @(negedge clk);
        end
        tests++;
        if (ec - last_start !== TO) begin
            fails++;
            $display("FAIL err_time: err %0d cycles after adp_start, want %0d",
                     ec - last_start, TO);
        end
        tests++;
        if (bus.in_ready !== 1'b1 || bus.adp_idx !== '0) begin
            fails++;
            $display("FAIL err_idle: rdy=%b idx=%0d want 1 0", bus.in_ready, bus.adp_idx);
        end
        tests++;
        if (we_cnt - w0 !== 1) begin
            fails++;
            $display("FAIL err_we: got %0d state_we want 1", we_cnt - w0);
        end
        drop_idx = -1;
        send(N, N, 1'b1, acc);
        wait_out(c);
        tests++;
        if (c !== acc + LAT || bus.err !== 1'b1) begin
            fails++;
            $display("FAIL after_err: lat=%0d err=%b want %0d 1", c - acc, bus.err, LAT);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int acc, c, w0;
        send(N, N, 1'b1, acc);
        while (cyc < acc + 8) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        tests++;
        if ({bus.in_ready, bus.busy, bus.err, bus.out_valid, bus.state_we} !== 5'b10000) begin
            fails++;
            $display("FAIL rst_mid_status: rdy/busy/err/ov/we=%b want 10000",
                     {bus.in_ready, bus.busy, bus.err, bus.out_valid, bus.state_we});
        end
        tests++;
        if ({bus.sample_we, bus.adp_start, bus.adp_idx} !== 4'b0) begin
            fails++;
            $display("FAIL rst_mid_idx: sw/st/idx=%b want 0",
                     {bus.sample_we, bus.adp_start, bus.adp_idx});
        end
        exp_start_q.delete();
        exp_we_q.delete();
        exp_out_q.delete();
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        w0 = we_cnt;
        repeat (15) @(negedge clk);
        tests++;
        if (we_cnt !== w0 || bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL rst_quiet: we=%0d busy=%b want 0 0", we_cnt - w0, bus.busy);
        end
        send(N, N, 1'b1, acc);
        wait_out(c);
        tests++;
        if (c !== acc + LAT) begin
            fails++;
            $display("FAIL rst_resume: lat %0d want %0d", c - acc, LAT);
        end
        @(negedge clk);
    endtask

    task automatic test_spurious();
        int acc, c;
        bus.out_ready = 1'b1;
        @(posedge clk);
        force_done = 1'b1;
        @(negedge clk);
        tests++;
        if (bus.state_we !== 1'b0 || bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL spur_idle: we=%b busy=%b want 0 0", bus.state_we, bus.busy);
        end
        @(posedge clk);
        force_done = 1'b0;
        @(negedge clk);
        tests++;
        if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL spur_idle_after: rdy=%b busy=%b want 1 0", bus.in_ready, bus.busy);
        end
        bus.out_ready = 1'b0;
        send(N, N, 1'b1, acc);
        wait_out(c);
        @(posedge clk);
        force_done = 1'b1;
        @(negedge clk);
        tests++;
        if (bus.state_we !== 1'b0 || bus.out_valid !== 1'b1) begin
            fails++;
            $display("FAIL spur_out: we=%b ov=%b want 0 1", bus.state_we, bus.out_valid);
        end
        @(posedge clk);
        force_done = 1'b0;
        @(negedge clk);
        tests++;
        if (bus.out_valid !== 1'b1 || int'(bus.adp_idx) !== N - 1) begin
            fails++;
            $display("FAIL spur_out_after: ov=%b idx=%0d want 1 %0d", bus.out_valid,
                     bus.adp_idx, N - 1);
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int a1, a2, c;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b1;
        accept(N, N, 1'b1, a1);
        accept(N, N, 1'b1, a2);
        tests++;
        if (a2 - a1 !== LAT + 1) begin
            fails++;
            $display("FAIL throughput: period %0d want %0d", a2 - a1, LAT + 1);
        end
`ifdef LWDF_STATUS_EN
        tests++;
        if (bus.stall_cnt !== 8'd10) begin
            fails++;
            $display("FAIL stall_first: got %0d want 10", bus.stall_cnt);
        end
`endif
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        wait_out(c);
        @(negedge clk);
    endtask

`ifdef LWDF_STATUS_EN
    task automatic test_stall_sat();
        int acc;
        do_reset();
        bus.out_ready = 1'b0;
        @(posedge clk);
        #1 bus.in_valid = 1'b1;
        accept(N, N, 1'b1, acc);
        repeat (300) @(negedge clk);
        tests++;
        if (bus.stall_cnt !== 8'd255) begin
            fails++;
            $display("FAIL stall_sat: got %0d want 255", bus.stall_cnt);
        end
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_timeout();
        test_reset_mid();
        test_spurious();
        test_back_to_back();
`ifdef LWDF_STATUS_EN
        test_stall_sat();
`endif
        repeat (5) @(negedge clk);
        tests++;
        if (exp_start_q.size() + exp_we_q.size() + exp_out_q.size() !== 0) begin
            fails++;
            $display("FAIL drain: %0d start, %0d we, %0d out still expected",
                     exp_start_q.size(), exp_we_q.size(), exp_out_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
